// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: multiply-accumulate by ten, one digit
// per cycle, most significant digit first, with a start/busy/done handshake.

module bcd_mac_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [3:0]            digit,
   output logic [DATA_WIDTH-1:0] acc_next,
   output logic                  err,
   output logic                  ovf
);
   // Four guard bits hold acc*10+15 for any acc, so carry-out is never lost.
   logic [DATA_WIDTH+3:0] acc_w;
   logic [DATA_WIDTH+3:0] wide;

   assign acc_w    = {4'b0, acc};
   assign wide     = (acc_w << 3) + (acc_w << 1) + {{DATA_WIDTH{1'b0}}, digit};
   assign acc_next = wide[DATA_WIDTH-1:0];
   assign ovf      = |wide[DATA_WIDTH+3:DATA_WIDTH];
   assign err      = (digit > 4'd9);
endmodule

module bcd_to_bin #(
   parameter int DIGITS     = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic                  err,
   output logic                  ovf
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] bin;
      logic                  err;
      logic                  ovf;
   } result_t;

   state_t                state;
   logic [4*DIGITS-1:0]   sreg;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic [CW-1:0]         cnt;
   logic                  err_st, ovf_st;
   logic                  step_err, step_ovf;
   result_t               res;

   bcd_mac_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .acc      (acc),
      .digit    (sreg[4*DIGITS-1 -: 4]),
      .acc_next (acc_next),
      .err      (step_err),
      .ovf      (step_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sreg   <= '0;
         acc    <= '0;
         cnt    <= '0;
         err_st <= 1'b0;
         ovf_st <= 1'b0;
         res    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sreg   <= bcd_in;
                  acc    <= '0;
                  cnt    <= '0;
                  err_st <= 1'b0;
                  ovf_st <= 1'b0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               sreg   <= sreg << 4;
               cnt    <= cnt + CW'(1);
               err_st <= err_st | step_err;
               ovf_st <= ovf_st | step_ovf;
               // Final digit: publish the result including this step's flags.
               if (cnt == LAST) begin
                  res.bin <= acc_next;
                  res.err <= err_st | step_err;
                  res.ovf <= ovf_st | step_ovf;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bin_out = res.bin;
   assign err     = res.err;
   assign ovf     = res.ovf;
endmodule
